// File: rtl/sem_proto_pkg.sv
// Shared protocol constants and types for the two-node semaphore (client and responder).
package sem_proto_pkg;

  localparam logic [15:0] SEM_START_BASE = 16'hFE00;
  localparam logic [15:0] SEM_STOP       = 16'hFEFF;
  localparam logic [15:0] SEM_POST       = 16'h0E10;
  localparam logic [15:0] SEM_WAIT       = 16'h0E20;
  localparam logic [15:0] SEM_IDLE       = 16'h0000;
  localparam logic [3:0]  SEM_TAG        = 4'hE;

  localparam int SEM_FULL_BIT  = 12;
  localparam int SEM_EMPTY_BIT = 13;

  typedef enum logic [1:0] {
    RSP_OK    = 2'b00,
    RSP_FULL  = 2'b01,
    RSP_EMPTY = 2'b10,
    RSP_ERR   = 2'b11
  } rsp_status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CMD,
    S_STOP
  } sem_state_e;

  function automatic logic [15:0] sem_start_word(input logic [3:0] prio);
    return SEM_START_BASE | {12'h000, prio};
  endfunction

endpackage

// File: rtl/sem_rsp_decode.sv
// Combinational decode of the responder's reply word for one node.
module sem_rsp_decode
  import sem_proto_pkg::*;
#(
  parameter int NODE_ID = 0
) (
  input  logic [15:0] sem_in,
  output logic        is_match,
  output logic        is_idle,
  output logic [1:0]  status
);

  localparam logic [3:0] NODE_TAG = 4'(NODE_ID + 1);

  assign is_idle  = (sem_in == SEM_IDLE);
  assign is_match = (sem_in[11:0] == {SEM_TAG, 4'h0, NODE_TAG}) && (sem_in[15:14] == 2'b00);
  // Full/empty both set is a malformed reply and falls out as the error code.
  assign status   = {sem_in[SEM_EMPTY_BIT], sem_in[SEM_FULL_BIT]};

endmodule

// File: rtl/semaphore_client.sv
// Semaphore initiator: lock request, post/wait command, reply decode with
// timeout/retry, and lock release, driving one node input of the responder.
module semaphore_client
  import sem_proto_pkg::*;
#(
  parameter int         NODE_ID     = 0,
  parameter logic [3:0] PRIORITY    = 4'd8,
  parameter int         ARB_CYCLES  = 2,
  parameter int         RSP_TIMEOUT = 16,
  parameter int         MAX_RETRY   = 3,
  parameter int         STOP_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  output logic [15:0] op_out,
  input  logic [15:0] sem_in,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status
);

  localparam int PH_MAX = (ARB_CYCLES > STOP_CYCLES) ? ARB_CYCLES : STOP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int WW     = $clog2(RSP_TIMEOUT + 1);
  localparam int RW     = $clog2(MAX_RETRY + 1);
  localparam logic [15:0] START_WORD = sem_start_word(PRIORITY);

  sem_state_e    state_q, state_d;
  logic [15:0]   op_out_q, op_out_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic          armed_q, armed_d;
  logic          cmd_op_q, cmd_op_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;

  logic       is_match, is_idle;
  logic [1:0] dec_status;

  sem_rsp_decode #(.NODE_ID(NODE_ID)) u_decode (
    .sem_in   (sem_in),
    .is_match (is_match),
    .is_idle  (is_idle),
    .status   (dec_status)
  );

  always_comb begin
    state_d      = state_q;
    op_out_d     = op_out_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    armed_d      = armed_q;
    cmd_op_d     = cmd_op_q;
    phase_d      = phase_q;
    wait_cnt_d   = wait_cnt_q;
    retry_cnt_d  = retry_cnt_q;

    // An idle word proves any earlier reply has been withdrawn.
    if ((state_q == S_REQ || state_q == S_CMD) && is_idle) armed_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        op_out_d = SEM_IDLE;
        if (cmd_valid) begin
          cmd_op_d    = cmd_op;
          retry_cnt_d = '0;
          phase_d     = '0;
          armed_d     = 1'b0;
          state_d     = S_REQ;
          op_out_d    = START_WORD;
        end
      end
      S_REQ: begin
        if (phase_q == PW'(ARB_CYCLES - 1)) begin
          state_d    = S_CMD;
          wait_cnt_d = '0;
          op_out_d   = cmd_op_q ? SEM_WAIT : SEM_POST;
        end else if (phase_q != PW'(PH_MAX)) begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_CMD: begin
        if (armed_q && is_match) begin
          rsp_status_d = dec_status;
          rsp_valid_d  = 1'b1;
          state_d      = S_STOP;
          phase_d      = '0;
          op_out_d     = SEM_STOP;
        end else if (wait_cnt_q == WW'(RSP_TIMEOUT - 1)) begin
          if (retry_cnt_q < RW'(MAX_RETRY - 1)) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            phase_d     = '0;
            armed_d     = 1'b0;
            state_d     = S_REQ;
            op_out_d    = START_WORD;
          end else begin
            rsp_status_d = RSP_ERR;
            rsp_valid_d  = 1'b1;
            state_d      = S_STOP;
            phase_d      = '0;
            op_out_d     = SEM_STOP;
          end
        end else if (wait_cnt_q != WW'(RSP_TIMEOUT)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (phase_q == PW'(STOP_CYCLES - 1)) begin
          state_d  = S_IDLE;
          op_out_d = SEM_IDLE;
        end else if (phase_q != PW'(PH_MAX)) begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        op_out_d = SEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      op_out_q     <= SEM_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_OK;
      armed_q      <= 1'b0;
      cmd_op_q     <= 1'b0;
      phase_q      <= '0;
      wait_cnt_q   <= '0;
      retry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_out_q     <= op_out_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      armed_q      <= armed_d;
      cmd_op_q     <= cmd_op_d;
      phase_q      <= phase_d;
      wait_cnt_q   <= wait_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign op_out     = op_out_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_semaphore_client.sv
// Directed bench for semaphore_client (node 0, priority 5); the responder is
// played by driving sem_in cycle by cycle.
module tb_semaphore_client;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [15:0] op_out;
  logic [15:0] sem_in;
  logic        rsp_valid;
  logic [1:0]  rsp_status;

  int pass_cnt = 0;
  int total    = 0;

  semaphore_client #(
    .NODE_ID(0), .PRIORITY(4'd5), .ARB_CYCLES(2),
    .RSP_TIMEOUT(16), .MAX_RETRY(3), .STOP_CYCLES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .op_out(op_out), .sem_in(sem_in),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; sem_in = 16'h0000;
    tick(); tick();
    total++; if (op_out !== 16'h0000) $display("FAIL reset_op_out got=%h exp=0000", op_out); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total++; if (rsp_status !== 2'b00) $display("FAIL reset_rsp_status got=%b exp=00", rsp_status); else pass_cnt++;
    RST = 1'b0;
    tick();
  endtask

  // One first-try transaction: start word x2, command, reply, stop x2, idle.
  task automatic run_txn(input string nm, input logic op, input logic [15:0] reply,
                         input logic [1:0] exp_st);
    logic [15:0] cmd_w;
    cmd_w = op ? 16'h0E20 : 16'h0E10;
    sem_in = 16'h0000; cmd_op = op; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++; if (op_out !== 16'hFE05) $display("FAIL %s_start got=%h exp=fe05", nm, op_out); else pass_cnt++;
    total++; if (cmd_ready !== 1'b0) $display("FAIL %s_busy_ready got=%b exp=0", nm, cmd_ready); else pass_cnt++;
    tick();
    total++; if (op_out !== 16'hFE05) $display("FAIL %s_start_hold got=%h exp=fe05", nm, op_out); else pass_cnt++;
    tick();
    total++; if (op_out !== cmd_w) $display("FAIL %s_cmd got=%h exp=%h", nm, op_out, cmd_w); else pass_cnt++;
    sem_in = reply;
    tick();
    total++; if (rsp_valid !== 1'b1) $display("FAIL %s_rsp_valid got=%b exp=1", nm, rsp_valid); else pass_cnt++;
    total++; if (rsp_status !== exp_st) $display("FAIL %s_status got=%b exp=%b", nm, rsp_status, exp_st); else pass_cnt++;
    total++; if (op_out !== 16'hFEFF) $display("FAIL %s_stop got=%h exp=feff", nm, op_out); else pass_cnt++;
    sem_in = 16'h0000;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL %s_rsp_pulse got=%b exp=0", nm, rsp_valid); else pass_cnt++;
    total++; if (op_out !== 16'hFEFF || rsp_status !== exp_st)
      $display("FAIL %s_stop_hold got=%h/%b exp=feff/%b", nm, op_out, rsp_status, exp_st); else pass_cnt++;
    tick();
    total++; if (op_out !== 16'h0000 || cmd_ready !== 1'b1)
      $display("FAIL %s_idle got=%h/%b exp=0000/1", nm, op_out, cmd_ready); else pass_cnt++;
  endtask

  task automatic test_post_ok();    run_txn("post_ok", 1'b0, 16'h0E01, 2'b00); endtask
  task automatic test_wait_empty(); run_txn("wait_empty", 1'b1, 16'h2E01, 2'b10); endtask
  task automatic test_post_full();  run_txn("post_full", 1'b0, 16'h1E01, 2'b01); endtask
  task automatic test_malformed();  run_txn("malformed", 1'b0, 16'h3E01, 2'b11); endtask

  // First attempt sees only the other node's reply (lost arbitration), retry wins.
  task automatic test_retry();
    logic early;
    early = 1'b0;
    sem_in = 16'h0000; cmd_op = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    sem_in = 16'h0E02;
    repeat (16) begin tick(); if (rsp_valid !== 1'b0) early = 1'b1; end
    total++; if (early) $display("FAIL retry_no_early_rsp got=1 exp=0"); else pass_cnt++;
    total++; if (op_out !== 16'hFE05) $display("FAIL retry_rerequest got=%h exp=fe05", op_out); else pass_cnt++;
    sem_in = 16'h0000;
    tick(); tick();
    total++; if (op_out !== 16'h0E10) $display("FAIL retry_cmd got=%h exp=0e10", op_out); else pass_cnt++;
    sem_in = 16'h0E01;
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00)
      $display("FAIL retry_rsp got=%b/%b exp=1/00", rsp_valid, rsp_status); else pass_cnt++;
    sem_in = 16'h0000;
    tick(); tick();
    total++; if (op_out !== 16'h0000) $display("FAIL retry_idle got=%h exp=0000", op_out); else pass_cnt++;
  endtask

  // Stale reply must not match until an idle word has been seen.
  task automatic test_stale_arming();
    logic early;
    early = 1'b0;
    sem_in = 16'h0E01; cmd_op = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (5) begin tick(); if (rsp_valid !== 1'b0) early = 1'b1; end
    total++; if (early) $display("FAIL stale_accepted got=1 exp=0"); else pass_cnt++;
    sem_in = 16'h0000;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL stale_idle_match got=%b exp=0", rsp_valid); else pass_cnt++;
    sem_in = 16'h0E01;
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00)
      $display("FAIL stale_armed_rsp got=%b/%b exp=1/00", rsp_valid, rsp_status); else pass_cnt++;
    sem_in = 16'h0000;
    tick(); tick();
  endtask

  // Reply stuck forever: three attempts of 18 cycles each, then error and stop word.
  task automatic test_stale_timeout();
    int k;
    sem_in = 16'h0E01; cmd_op = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (k < 100) begin
      tick(); k++;
      if (rsp_valid === 1'b1) break;
    end
    total++; if (k !== 54) $display("FAIL timeout_latency got=%0d exp=54", k); else pass_cnt++;
    total++; if (rsp_status !== 2'b11) $display("FAIL timeout_status got=%b exp=11", rsp_status); else pass_cnt++;
    total++; if (op_out !== 16'hFEFF) $display("FAIL timeout_stop got=%h exp=feff", op_out); else pass_cnt++;
    sem_in = 16'h0000;
    tick(); tick();
    total++; if (op_out !== 16'h0000 || cmd_ready !== 1'b1)
      $display("FAIL timeout_idle got=%h/%b exp=0000/1", op_out, cmd_ready); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    sem_in = 16'h0000; cmd_op = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_op = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0) $display("FAIL busy_ready got=%b exp=0", cmd_ready); else pass_cnt++;
    tick();
    cmd_valid = 1'b0;
    total++; if (op_out !== 16'h0E10) $display("FAIL busy_cmd_kept got=%h exp=0e10", op_out); else pass_cnt++;
    sem_in = 16'h0E01;
    tick();
    sem_in = 16'h0000;
    tick(); tick(); tick(); tick();
    total++; if (op_out !== 16'h0000 || cmd_ready !== 1'b1)
      $display("FAIL busy_not_queued got=%h/%b exp=0000/1", op_out, cmd_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    sem_in = 16'h0000; cmd_op = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    total++; if (op_out !== 16'h0E10) $display("FAIL rstmid_in_cmd got=%h exp=0e10", op_out); else pass_cnt++;
    RST = 1'b1;
    tick();
    total++; if (op_out !== 16'h0000) $display("FAIL rstmid_op_out got=%h exp=0000", op_out); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); else pass_cnt++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    RST = 1'b0;
    tick();
    total++; if (op_out !== 16'h0000) $display("FAIL rstmid_no_stop got=%h exp=0000", op_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_post_ok();
    test_wait_empty();
    test_post_full();
    test_malformed();
    test_retry();
    test_stale_arming();
    test_stale_timeout();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/semaphore_client.md
# semaphore_client

Initiator end of the two-node semaphore protocol: accepts one post/wait command per transaction from local logic and drives a 16-bit op word into one node input of the semaphore responder. It requests the lock with a priority start word, issues the command, decodes the responder's reply and releases the lock with the stop word. It sits between a local requester (MCU bridge or fabric master) and one `in_op_nodeN` / `out` pair of the semaphore.

## Interface
- `NODE_ID`, 0: node index, 0 or 1. Expected reply low nibble is `NODE_ID+1`.
- `PRIORITY`, 4'd8: request priority, 1..15. Value 0 is illegal because 0 means "no request".
- `ARB_CYCLES`, 2: cycles the start word is held before the command is driven. Minimum 1.
- `RSP_TIMEOUT`, 16: cycles in CMD without a valid reply before a retry.
- `MAX_RETRY`, 3: REQ/CMD attempts before the transaction fails.
- `STOP_CYCLES`, 2: cycles the stop word is held. Minimum 1.
- `CLK` input, 1 bit: the single clock. All logic is on its rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `cmd_valid` input, 1 bit: local command request.
- `cmd_ready` output, 1 bit: high only in IDLE.
- `cmd_op` input, 1 bit: 0 = post, 1 = wait. Sampled on handshake.
- `op_out` output, 16 bits: registered; drives the responder's `in_op_nodeN`.
- `sem_in` input, 16 bits: the responder's `out`.
- `rsp_valid` output, 1 bit: one-cycle pulse when the transaction ends.
- `rsp_status` output, 2 bits: 00 ok, 01 full, 10 empty, 11 error (timeout). Held until the next `rsp_valid`.

## Operation
- Protocol words:
  - start = 0xFE00 | PRIORITY
  - stop = 0xFEFF
  - post = 0x0E10
  - wait = 0x0E20
  - idle = 0x0000
- Reply word layout: [11:8] = 4'hE; [3:0] = node id + 1; [7:4] = 0; bit 12 = full; bit 13 = empty; [15:14] = 0.
- A reply is a match when all of the following hold: `armed` is set, `sem_in[11:0]` equals `{4'hE, 4'h0, NODE_ID+1}`, and `sem_in[15:14]` = 0.
  - Status is taken from `sem_in[13:12]`.
  - 2'b11 is a malformed reply: reported as error, no retry.
- `armed`: cleared on every entry to REQ. Set in REQ or CMD when `sem_in == 0x0000`. This rejects a stale reply held from a previous transaction.
- FSM states: IDLE, REQ, CMD, STOP.
  - **IDLE**: `op_out` = 0x0000, `cmd_ready` = 1.
    - `cmd_valid & cmd_ready`: latch `cmd_op`, clear `retry_cnt`, go to REQ.
  - **REQ**: `op_out` = start word. Held ARB_CYCLES cycles, then go to CMD and clear `wait_cnt`.
  - **CMD**: `op_out` = post or wait word.
    - Match: latch status, pulse `rsp_valid`, go to STOP.
    - `wait_cnt == RSP_TIMEOUT-1` without a match, and `retry_cnt < MAX_RETRY-1`: increment `retry_cnt`, go to REQ. Lost arbitration is not an error until retries are exhausted.
    - `wait_cnt == RSP_TIMEOUT-1` without a match, and retries exhausted: status 11, pulse `rsp_valid`, go to STOP.
  - **STOP**: `op_out` = 0xFEFF for STOP_CYCLES cycles, then go to IDLE. The stop word is always sent, including after an error.
- If a match and a timeout occur in the same cycle, the match wins.
- `cmd_valid` while busy is ignored (`cmd_ready` = 0). The command is not queued.
- Counter widths are `$clog2(max+1)`. Counters saturate and never wrap.

## Timing
- Reset values (one edge with `RST` high): state IDLE, `op_out` 0x0000, `rsp_valid` 0, `rsp_status` 00, `armed` 0, all counters 0, `cmd_ready` 1.
- Reset mid-transaction aborts immediately and sends no stop word. The responder must be reset in the same domain.
- Handshake at edge t: `op_out` shows the start word from t+1.
- The command word appears at t+1+ARB_CYCLES.
- A match sampled at edge m gives `rsp_valid` high for cycle m+1 and the stop word from m+1.
- After a match, `op_out` returns to 0x0000 at m+1+STOP_CYCLES. `cmd_ready` rises in the same cycle.
- Minimum transaction, first-try grant with reply one cycle after the command: handshake to `rsp_valid` = ARB_CYCLES + 2 cycles.

## Structure
- Shared package `sem_proto_pkg` holds:
  - the start base, stop, post, wait and tag constants;
  - the full (12) and empty (13) bit indices;
  - the `rsp_status` encoding;
  - the FSM state enum.

  The responder and client both import it.
- One combinational sub-module, `sem_rsp_decode`: takes `sem_in` and `NODE_ID`, produces `is_match`, `is_idle` (`sem_in == 0`) and `status[1:0]`.

## Test plan
- Post, NODE_ID 0, PRIORITY 5, responder unlocked with coins 0 → `op_out` sequence 0xFE05, 0x0E10, 0xFEFF, 0x0000; `rsp_status` 00; responder coins 1.
- Wait with coins 0 → reply 0x2E01 → `rsp_status` 10, one `rsp_valid` pulse, stop word sent.
- Post with coins 10 → reply 0x1E01 → `rsp_status` 01.
- Both nodes request at the same time: node 0 with PRIORITY 3, node 1 with PRIORITY 9.
  - Node 1 is served first (`rsp_status` 00).
  - Node 0 retries and completes after node 1's stop, with `retry_cnt` ≥ 1 and no error.
- `sem_in` stuck at 0x0E01 from a previous session → not accepted until 0x0000 is seen. With `sem_in` held at 0x0E01, MAX_RETRY 3 and RSP_TIMEOUT 16: `rsp_status` 11 after 3 attempts, then stop word.
- `RST` asserted in CMD → next cycle `op_out` 0x0000, `cmd_ready` 1, `rsp_valid` 0. `cmd_valid` while busy is ignored.
